// File: rtl/rev_count_ctrl.sv
// rev_count_ctrl: run/pause/direction sequencer and tick generator for the stopwatch reversible counter.
// Build option REV_CTRL_WRAP_EN: a bound hit reloads the counter and keeps running instead of halting.
module rev_count_ctrl #(
    parameter int unsigned DIV_MAX = 5_000_000 - 1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        btn_run,
    input  logic        btn_dir,
    input  logic        btn_clr,
    input  logic [15:0] limit,
    input  logic [15:0] cnt_q,
    output logic        cnt_ce,
    output logic        cnt_up,
    output logic        cnt_clr,
    output logic        cnt_ld,
    output logic [15:0] cnt_ld_val,
    output logic [1:0]  state
);

    localparam int unsigned   PW        = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t        r_state, w_state_nx;
    logic [PW-1:0] r_presc, w_presc_nx;
    logic          r_run_prev, r_dir_prev, r_clr_prev;
    logic          r_run_ev, r_dir_ev, r_clr_ev;
    logic          r_dir_pend, w_pend_nx;
    logic          r_tick_d, w_tick_nx;
    logic          r_cnt_ce, w_ce_nx;
    logic          r_cnt_up, w_up_nx;
    logic          r_cnt_clr, w_clr_nx;
    logic          r_cnt_ld, w_ld_nx;
    logic [15:0]   r_cnt_ld_val, w_ld_val_nx;
    logic          w_bound_hit;

    assign w_bound_hit = r_cnt_up ? (cnt_q >= limit) : (cnt_q == 16'h0000);

    // NOTE: every output of this block is written a default first, so no path can infer a latch.
    always_comb begin
        w_state_nx  = r_state;
        w_presc_nx  = r_presc;
        w_ce_nx     = 1'b0;
        w_clr_nx    = 1'b0;
        w_ld_nx     = 1'b0;
        w_ld_val_nx = r_cnt_ld_val;
        w_tick_nx   = 1'b0;
        w_pend_nx   = r_dir_pend ^ r_dir_ev;
        // Direction reaches the counter only in the cycle after a tick, never alongside cnt_ce.
        w_up_nx     = (r_state != RUN || r_tick_d) ? r_dir_pend : r_cnt_up;

        if (r_clr_ev) begin
            w_clr_nx   = 1'b1;
            w_state_nx = IDLE;
            w_presc_nx = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_run_ev) begin
                        w_state_nx = RUN;
                        w_presc_nx = '0;
                    end
                end
                RUN: begin
                    if (r_run_ev) begin
                        w_state_nx = PAUSE;
                    end else if (r_presc == PRESC_MAX) begin
                        w_presc_nx = '0;
                        w_tick_nx  = 1'b1;
                        if (!w_bound_hit) begin
                            w_ce_nx = 1'b1;
                        end else begin
`ifdef REV_CTRL_WRAP_EN
                            w_ld_nx     = 1'b1;
                            w_ld_val_nx = r_cnt_up ? 16'h0000 : limit;
`else
                            w_state_nx = HALT;
`endif
                        end
                    end else begin
                        w_presc_nx = r_presc + PW'(1);
                    end
                end
                PAUSE: begin
                    if (r_run_ev) w_state_nx = RUN;
                end
                HALT: begin
                    if (r_run_ev) begin
                        w_state_nx = RUN;
                        w_presc_nx = '0;
                        if (r_cnt_up) begin
                            w_clr_nx = 1'b1;
                        end else begin
                            w_ld_nx     = 1'b1;
                            w_ld_val_nx = limit;
                        end
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // NOTE: registers take <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_run_prev   <= 1'b0;
            r_dir_prev   <= 1'b0;
            r_clr_prev   <= 1'b0;
            r_run_ev     <= 1'b0;
            r_dir_ev     <= 1'b0;
            r_clr_ev     <= 1'b0;
            r_state      <= IDLE;
            r_presc      <= '0;
            r_dir_pend   <= 1'b1;
            r_tick_d     <= 1'b0;
            r_cnt_ce     <= 1'b0;
            r_cnt_up     <= 1'b1;
            r_cnt_clr    <= 1'b0;
            r_cnt_ld     <= 1'b0;
            r_cnt_ld_val <= 16'h0000;
        end else begin
            r_run_prev   <= btn_run;
            r_dir_prev   <= btn_dir;
            r_clr_prev   <= btn_clr;
            r_run_ev     <= btn_run & ~r_run_prev;
            r_dir_ev     <= btn_dir & ~r_dir_prev;
            r_clr_ev     <= btn_clr & ~r_clr_prev;
            r_state      <= w_state_nx;
            r_presc      <= w_presc_nx;
            r_dir_pend   <= w_pend_nx;
            r_tick_d     <= w_tick_nx;
            r_cnt_ce     <= w_ce_nx;
            r_cnt_up     <= w_up_nx;
            r_cnt_clr    <= w_clr_nx;
            r_cnt_ld     <= w_ld_nx;
            r_cnt_ld_val <= w_ld_val_nx;
        end
    end

    assign cnt_ce     = r_cnt_ce;
    assign cnt_up     = r_cnt_up;
    assign cnt_clr    = r_cnt_clr;
    assign cnt_ld     = r_cnt_ld;
    assign cnt_ld_val = r_cnt_ld_val;
    assign state      = r_state;

endmodule
